// File: rtl/arch_state_dump.sv
// End-of-run architectural state dumper: after a halt and a drain window, walks
// every architectural register through SRAT -> PRF and streams it out on valid/ready.
module arch_state_dump #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned NUM_AREG     = 8,
    parameter int unsigned AREG_W       = 3,
    parameter int unsigned PTAG_W       = 6,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    output logic [AREG_W-1:0] srat_areg,
    input  logic [PTAG_W-1:0] srat_ptag,
    output logic [PTAG_W-1:0] prf_raddr,
    input  logic [DATA_W-1:0] prf_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [AREG_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam int unsigned       CNT_W    = 8;
    localparam logic [AREG_W-1:0] LAST_IDX = AREG_W'(NUM_AREG - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_LOOKUP, S_READ, S_SEND, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AREG_W-1:0] idx_q, idx_d;
    logic [AREG_W-1:0] srat_areg_q, srat_areg_d;
    logic [PTAG_W-1:0] prf_raddr_q, prf_raddr_d;
    logic              dump_valid_q, dump_valid_d;
    logic [AREG_W-1:0] dump_idx_q, dump_idx_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;
    logic              dump_last_q, dump_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic              hs;

    assign hs = dump_valid_q && dump_ready;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            srat_areg_q  <= '0;
            prf_raddr_q  <= '0;
            dump_valid_q <= 1'b0;
            dump_idx_q   <= '0;
            dump_data_q  <= '0;
            dump_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            checksum_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            srat_areg_q  <= srat_areg_d;
            prf_raddr_q  <= prf_raddr_d;
            dump_valid_q <= dump_valid_d;
            dump_idx_q   <= dump_idx_d;
            dump_data_q  <= dump_data_d;
            dump_last_q  <= dump_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            checksum_q   <= checksum_d;
        end
    end

    // Next state, drain counter and register index
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (halt) begin
                    state_d = S_DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                    idx_d   = '0;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) state_d = S_LOOKUP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_LOOKUP: state_d = S_READ;
            S_READ:   state_d = S_SEND;
            S_SEND: begin
                if (hs) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + AREG_W'(1);
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_DONE:   state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Registered outputs, derived from the upcoming state
    always_comb begin
        srat_areg_d  = (state_d == S_IDLE) ? '0 : idx_d;
        prf_raddr_d  = (state_q == S_LOOKUP) ? srat_ptag : prf_raddr_q;
        dump_data_d  = (state_q == S_READ) ? prf_rdata : dump_data_q;
        dump_valid_d = (state_d == S_SEND);
        dump_idx_d   = idx_d;
        dump_last_d  = (state_d == S_SEND) && (idx_d == LAST_IDX);
        busy_d       = (state_d == S_DRAIN) || (state_d == S_LOOKUP) ||
                       (state_d == S_READ)  || (state_d == S_SEND);
        done_d       = (state_d == S_DONE);
        checksum_d   = checksum_q;
        if ((state_q == S_IDLE) && halt) checksum_d = '0;
        else if (hs)                     checksum_d = checksum_q ^ dump_data_q;
    end

    assign srat_areg  = srat_areg_q;
    assign prf_raddr  = prf_raddr_q;
    assign dump_valid = dump_valid_q;
    assign dump_idx   = dump_idx_q;
    assign dump_data  = dump_data_q;
    assign dump_last  = dump_last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_arch_state_dump.sv
// Directed bench for arch_state_dump with SRAT/PRF models and a handshake monitor.
module tb_arch_state_dump;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic [2:0]  srat_areg;
    logic [5:0]  srat_ptag;
    logic [5:0]  prf_raddr;
    logic [15:0] prf_rdata;
    logic        dump_valid;
    logic        dump_ready;
    logic [2:0]  dump_idx;
    logic [15:0] dump_data;
    logic        dump_last;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    logic [5:0]  srat_map [8];
    logic [15:0] prf_mem  [64];
    logic [15:0] exp_data [8];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int nw    = 0;
    logic [2:0]  w_idx  [32];
    logic [15:0] w_data [32];
    logic        w_last [32];
    int          w_cyc  [32];

    arch_state_dump dut (
        .clk        (clk),
        .rst        (rst),
        .halt       (halt),
        .srat_areg  (srat_areg),
        .srat_ptag  (srat_ptag),
        .prf_raddr  (prf_raddr),
        .prf_rdata  (prf_rdata),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    assign srat_ptag = srat_map[srat_areg];
    assign prf_rdata = prf_mem[prf_raddr];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record each word that will be accepted at the next rising edge
    always @(negedge clk) begin
        if (rst && dump_valid && dump_ready && nw < 32) begin
            w_idx[nw]  = dump_idx;
            w_data[nw] = dump_data;
            w_last[nw] = dump_last;
            w_cyc[nw]  = cyc;
            nw = nw + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        halt = 1'b0;
        dump_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        nw = 0;
    endtask

    task automatic pulse_halt(output int t0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int budget, output int t_done);
        t_done = -1;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (done) begin
                t_done = cyc;
                break;
            end
        end
        check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_valid"}, {31'd0, dump_valid}, 32'd0);
        check({pfx, "_busy"},  {31'd0, busy}, 32'd0);
        check({pfx, "_done"},  {31'd0, done}, 32'd0);
        check({pfx, "_last"},  {31'd0, dump_last}, 32'd0);
        check({pfx, "_areg"},  {29'd0, srat_areg}, 32'd0);
        check({pfx, "_raddr"}, {26'd0, prf_raddr}, 32'd0);
        check({pfx, "_idx"},   {29'd0, dump_idx}, 32'd0);
        check({pfx, "_data"},  {16'd0, dump_data}, 32'd0);
        check({pfx, "_csum"},  {16'd0, checksum}, 32'd0);
    endtask

    task automatic check_words();
        check("nwords", nw, 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("w%0d_idx", i),  {29'd0, w_idx[i]}, i);
            check($sformatf("w%0d_data", i), {16'd0, w_data[i]}, {16'd0, exp_data[i]});
            check($sformatf("w%0d_last", i), {31'd0, w_last[i]}, (i == 7) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic default_map();
        for (int p = 0; p < 64; p++) prf_mem[p] = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            srat_map[i]    = 6'(8 + i);
            prf_mem[8 + i] = 16'h1110 + 16'(i);
            exp_data[i]    = 16'h1110 + 16'(i);
        end
    endtask

    initial begin
        int t0, td;
        logic [15:0] hold_data, exp_sum;
        logic [2:0]  hold_idx;
        logic        hold_last, stalled;

        rst = 1'b0;
        halt = 1'b0;
        dump_ready = 1'b1;
        default_map();

        // Reset then idle
        #13;
        check_outputs_zero("rst");
        rst = 1'b1;
        tick();
        nw = 0;
        repeat (50) tick();
        check("idle_nwords", nw, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Basic dump with ready tied high
        pulse_halt(t0);
        check("basic_busy", {31'd0, busy}, 32'd1);
        wait_done(60, td);
        check_words();
        for (int i = 0; i < 8; i++)
            check($sformatf("w%0d_time", i), w_cyc[i] - t0, 6 + 3 * i);
        check("basic_done_time", td - t0, 32'd28);
        check("basic_csum", {16'd0, checksum}, 32'h0000);
        check("basic_busy_end", {31'd0, busy}, 32'd0);

        // Backpressure on word 3
        do_reset();
        pulse_halt(t0);
        stalled = 1'b0;
        for (int k = 0; k < 80 && !done; k++) begin
            tick();
            if (dump_valid && dump_idx == 3'd3 && !stalled) begin
                stalled = 1'b1;
                dump_ready = 1'b0;
                hold_data = dump_data;
                hold_idx  = dump_idx;
                hold_last = dump_last;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check("bp_valid", {31'd0, dump_valid}, 32'd1);
                    check("bp_data", {16'd0, dump_data}, {16'd0, hold_data});
                    check("bp_idx", {29'd0, dump_idx}, {29'd0, hold_idx});
                    check("bp_last", {31'd0, dump_last}, {31'd0, hold_last});
                end
                dump_ready = 1'b1;
            end
        end
        check("bp_stalled", {31'd0, stalled}, 32'd1);
        check("bp_done", {31'd0, done}, 32'd1);
        check_words();
        check("bp_csum", {16'd0, checksum}, 32'h0000);

        // Remapped tags: only areg 2 carries data
        do_reset();
        for (int p = 0; p < 64; p++) prf_mem[p] = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            srat_map[i] = 6'(i);
            exp_data[i] = 16'h0000;
        end
        srat_map[2]  = 6'd63;
        prf_mem[63]  = 16'hBEEF;
        exp_data[2]  = 16'hBEEF;
        pulse_halt(t0);
        wait_done(60, td);
        check_words();
        check("remap_csum", {16'd0, checksum}, 32'h0000BEEF);

        // Halt held high, then re-pulsed after done
        do_reset();
        default_map();
        halt = 1'b1;
        repeat (40) tick();
        halt = 1'b0;
        check("glitch_done", {31'd0, done}, 32'd1);
        pulse_halt(t0);
        repeat (20) tick();
        check_words();
        check("glitch_done2", {31'd0, done}, 32'd1);
        check("glitch_valid", {31'd0, dump_valid}, 32'd0);
        check("glitch_csum", {16'd0, checksum}, 32'h0000);

        // Reset during word 4, then a fresh dump with distinct data
        do_reset();
        pulse_halt(t0);
        stalled = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (dump_valid && dump_idx == 3'd4) begin
                stalled = 1'b1;
                break;
            end
        end
        check("mid_reached_w4", {31'd0, stalled}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_outputs_zero("mid");
        tick();
        rst = 1'b1;
        tick();
        exp_sum = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            prf_mem[8 + i] = 16'hA000 + 16'(i) * 16'h0123;
            exp_data[i]    = 16'hA000 + 16'(i) * 16'h0123;
            exp_sum        = exp_sum ^ exp_data[i];
        end
        nw = 0;
        pulse_halt(t0);
        wait_done(60, td);
        check_words();
        check("mid_csum", {16'd0, checksum}, {16'd0, exp_sum});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
